// File: rtl/tlul_to_mem_device_if.sv
`default_nettype none
// ============================================================================
// Module   : tlul_to_mem_device_if
// Brief    : TL-UL A/D channel pair plus req/gnt/rvalid memory port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface tlul_to_mem_device_if;
  // TL-UL A channel and D-channel ready (from xbar)
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_ready;
  // TL-UL D channel and A-channel ready (to xbar)
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_user;
  logic        d_error;
  logic        a_ready;
  // Memory port
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output gnt, rvalid, rdata, err,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error, a_ready,
    input  req, we, be, addr, wdata
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  gnt, rvalid, rdata, err,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error, a_ready,
    output req, we, be, addr, wdata
  );
endinterface
`default_nettype wire

// File: rtl/tlul_to_mem_device.sv
`default_nettype none
// ============================================================================
// Module   : tlul_to_mem_device
// Brief    : TL-UL device responder driving an in-order req/gnt/rvalid memory.
// Revision : 1.0 - initial release
// ============================================================================
module tlul_to_mem_device #(
  parameter int OUTSTANDING = 2
) (
  input  wire                   clk_i,
  input  wire                   rst_i,
  tlul_to_mem_device_if.slave   bus
);

  localparam int c_ptr_w = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int c_cnt_w = $clog2(OUTSTANDING + 1);
  localparam int c_sum_w = $clog2(2 * OUTSTANDING);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(OUTSTANDING);

  logic [7:0]             r_src  [OUTSTANDING];
  logic [1:0]             r_size [OUTSTANDING];
  logic [31:0]            r_data [OUTSTANDING];
  logic [OUTSTANDING-1:0] r_is_get;
  logic [OUTSTANDING-1:0] r_filled;
  logic [OUTSTANDING-1:0] r_err;
  logic [c_ptr_w-1:0]     r_wptr;
  logic [c_ptr_w-1:0]     r_rptr;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     r_pend;

  logic [3:0]             w_span;
  logic                   w_opcode_ok;
  logic                   w_aligned;
  logic                   w_good;
  logic                   w_not_full;
  logic                   w_pend_zero;
  logic                   w_req;
  logic                   w_a_ready;
  logic                   w_push;
  logic                   w_push_good;
  logic                   w_fill;
  logic                   w_dvalid;
  logic                   w_pop;
  logic [c_sum_w-1:0]     w_sum;
  logic [c_ptr_w-1:0]     w_fill_idx;

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(OUTSTANDING - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Byte lanes covered by the access; only meaningful when size/alignment are legal.
  always_comb begin
    w_span = 4'b1111;
    case (bus.a_size)
      2'd0:    w_span = 4'b0001 << bus.a_address[1:0];
      2'd1:    w_span = 4'b0011 << {bus.a_address[1], 1'b0};
      default: w_span = 4'b1111;
    endcase
  end

  assign w_opcode_ok = (bus.a_opcode == 3'd4) || (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1);
  assign w_aligned   = (bus.a_size == 2'd0) ||
                       ((bus.a_size == 2'd1) && !bus.a_address[0]) ||
                       ((bus.a_size == 2'd2) && (bus.a_address[1:0] == 2'b00));
  assign w_good      = w_opcode_ok && (bus.a_size != 2'd3) && w_aligned &&
                       ((bus.a_mask & ~w_span) == 4'b0000) &&
                       !((bus.a_opcode == 3'd0) && (bus.a_mask != w_span));

  assign w_not_full  = (r_cnt != c_depth);
  assign w_pend_zero = (r_pend == '0);
  assign w_req       = bus.a_valid && w_good && w_not_full;
  // A bad request waits for the memory to drain so its error response stays in order.
  assign w_a_ready   = w_good ? (w_req && bus.gnt)
                              : (bus.a_valid && w_not_full && w_pend_zero);
  assign w_push      = bus.a_valid && w_a_ready;
  assign w_push_good = w_push && w_good;
  assign w_fill      = bus.rvalid && !w_pend_zero;
  assign w_dvalid    = (r_cnt != '0) && r_filled[r_rptr];
  assign w_pop       = w_dvalid && bus.d_ready;

  // Oldest unfilled slot sits pend entries behind the write pointer.
  always_comb begin
    w_sum = c_sum_w'(r_wptr) + c_sum_w'(OUTSTANDING) - c_sum_w'(r_pend);
    if (w_sum >= c_sum_w'(OUTSTANDING)) begin
      w_sum = w_sum - c_sum_w'(OUTSTANDING);
    end
    w_fill_idx = c_ptr_w'(w_sum);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        r_src[i]  <= '0;
        r_size[i] <= '0;
        r_data[i] <= '0;
      end
      r_is_get <= '0;
      r_filled <= '0;
      r_err    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_pend   <= '0;
    end else begin
      if (w_push) begin
        r_src[r_wptr]    <= bus.a_source;
        r_size[r_wptr]   <= bus.a_size;
        r_data[r_wptr]   <= '0;
        r_is_get[r_wptr] <= (bus.a_opcode == 3'd4);
        r_filled[r_wptr] <= !w_good;
        r_err[r_wptr]    <= !w_good;
        r_wptr           <= f_inc(r_wptr);
      end
      if (w_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_err[w_fill_idx]    <= bus.err;
        r_data[w_fill_idx]   <= r_is_get[w_fill_idx] ? bus.rdata : 32'h0;
      end
      if (w_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
        2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
        default: r_cnt <= r_cnt;
      endcase
      case ({w_push_good, w_fill})
        2'b10:   r_pend <= r_pend + c_cnt_w'(1);
        2'b01:   r_pend <= r_pend - c_cnt_w'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

  assign bus.req      = w_req;
  assign bus.a_ready  = w_a_ready;
  assign bus.we       = (bus.a_opcode != 3'd4);
  assign bus.be       = bus.a_mask;
  assign bus.addr     = {bus.a_address[31:2], 2'b00};
  assign bus.wdata    = bus.a_data;

  assign bus.d_valid  = w_dvalid;
  assign bus.d_opcode = r_is_get[r_rptr] ? 3'd1 : 3'd0;
  assign bus.d_param  = 3'd0;
  assign bus.d_size   = r_size[r_rptr];
  assign bus.d_source = r_src[r_rptr];
  assign bus.d_sink   = 1'b0;
  assign bus.d_data   = r_data[r_rptr];
  assign bus.d_user   = 1'b0;
  assign bus.d_error  = r_err[r_rptr];

`ifndef SYNTHESIS
  a_rvalid_has_pend : assert property (@(posedge clk_i) disable iff (rst_i)
                                       !(bus.rvalid && (r_pend == '0)))
    else $warning("rvalid_i without a pending request was dropped");
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlul_to_mem_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlul_to_mem_device
// Brief    : Randomized bench with a queue-based model of the TL-UL responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlul_to_mem_device;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlul_to_mem_device_if bus();

  tlul_to_mem_device #(.OUTSTANDING(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  src;
    logic [1:0]  size;
    bit          is_get;
    bit          filled;
    logic [31:0] data;
    bit          err;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          cyc;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t mem_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stale_n = 0;

  bit          a_pend = 0;
  logic [2:0]  a_op;
  logic [1:0]  a_sz;
  logic [31:0] a_adr;
  logic [3:0]  a_msk;
  logic [31:0] a_dat;
  logic [7:0]  a_src;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Request legality straight from the protocol rules.
  function automatic bit is_bad(input logic [2:0] op, input logic [1:0] sz,
                                input logic [31:0] adr, input logic [3:0] msk);
    int nb;
    int off;
    logic [3:0] lanes;
    if (!(op == 3'd4 || op == 3'd0 || op == 3'd1)) return 1'b1;
    if (sz > 2'd2) return 1'b1;
    nb  = 1 << sz;
    off = int'(adr % 4);
    if ((adr % nb) != 0) return 1'b1;
    lanes = 4'(((1 << nb) - 1) << off);
    if ((msk & ~lanes) != 4'b0) return 1'b1;
    if (op == 3'd0 && msk != lanes) return 1'b1;
    return 1'b0;
  endfunction

  task automatic new_req();
    int r;
    int nb;
    logic [3:0] lanes;
    r = $urandom_range(0, 99);
    if (r < 40)      a_op = 3'd4;
    else if (r < 65) a_op = 3'd0;
    else if (r < 92) a_op = 3'd1;
    else begin
      a_op = 3'($urandom_range(2, 7));
      if (a_op == 3'd4) a_op = 3'd6;
    end
    a_sz  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    nb    = (a_sz == 2'd3) ? 4 : (1 << a_sz);
    a_adr = $urandom;
    if ($urandom_range(0, 9) != 0) a_adr = a_adr - (a_adr % nb);
    lanes = 4'(((1 << nb) - 1) << (a_adr % 4));
    if ($urandom_range(0, 9) == 0) a_msk = 4'($urandom);
    else if (a_op == 3'd1) begin
      a_msk = lanes & 4'($urandom);
      if (a_msk == 4'b0) a_msk = lanes;
    end else a_msk = lanes;
    a_dat = $urandom;
    a_src = 8'($urandom);
  endtask

  // One clock: drive at negedge, predict/check just after, then commit model at posedge.
  task automatic step(input int new_pct, input int gnt_pct, input int dr_pct, input int rv_pct);
    bit rv, stale_now, good, room, exp_req, exp_ardy, acc, dv_exp, pop, found;
    logic [31:0] d;
    bit e;
    exp_t ne;
    @(negedge clk);
    stale_now = (stale_n > 0);
    if (!a_pend && !stale_now && ($urandom_range(0, 99) < new_pct)) begin
      new_req();
      a_pend = 1;
    end
    bus.a_valid   = a_pend;
    bus.a_opcode  = a_op;
    bus.a_size    = a_sz;
    bus.a_address = a_adr;
    bus.a_mask    = a_msk;
    bus.a_data    = a_dat;
    bus.a_source  = a_src;
    bus.gnt       = ($urandom_range(0, 99) < gnt_pct);
    bus.d_ready   = ($urandom_range(0, 99) < dr_pct);
    rv = 0;
    if (stale_now) begin
      bus.rvalid = 1'b1;
      bus.rdata  = $urandom;
      bus.err    = 1'b1;
      stale_n--;
    end else begin
      rv = (mem_q.size() > 0) && (mem_q[0].cyc < cyc) && ($urandom_range(0, 99) < rv_pct);
      bus.rvalid = rv;
      bus.rdata  = rv ? mem_q[0].data : $urandom;
      bus.err    = rv ? mem_q[0].err : 1'($urandom);
    end
    #1;
    good     = !is_bad(a_op, a_sz, a_adr, a_msk);
    room     = (exp_q.size() < N);
    exp_req  = a_pend && good && room;
    exp_ardy = a_pend && room && (good ? bus.gnt : (mem_q.size() == 0));
    check_val("req", bus.req, exp_req);
    check_val("a_ready", bus.a_ready, exp_ardy);
    acc = a_pend && exp_ardy;
    if (acc) begin
      ne.src    = a_src;
      ne.size   = a_sz;
      ne.is_get = (a_op == 3'd4);
      if (good) begin
        check_val("we", bus.we, a_op != 3'd4);
        check_val("be", bus.be, a_msk);
        check_val("addr", bus.addr, a_adr & 32'hFFFF_FFFC);
        check_val("wdata", bus.wdata, a_dat);
        d = $urandom;
        e = ($urandom_range(0, 9) == 0);
        mem_q.push_back('{data: d, err: e, cyc: cyc});
        ne.filled = 0;
        ne.data   = ne.is_get ? d : 32'h0;
        ne.err    = e;
      end else begin
        ne.filled = 1;
        ne.data   = 32'h0;
        ne.err    = 1;
      end
    end
    dv_exp = (exp_q.size() > 0) && exp_q[0].filled;
    check_val("d_valid", bus.d_valid, dv_exp);
    pop = dv_exp && bus.d_ready;
    if (pop) begin
      check_val("d_opcode", bus.d_opcode, exp_q[0].is_get ? 3'd1 : 3'd0);
      check_val("d_source", bus.d_source, exp_q[0].src);
      check_val("d_size", bus.d_size, exp_q[0].size);
      check_val("d_error", bus.d_error, exp_q[0].err);
      check_val("d_data", bus.d_data, exp_q[0].data);
      check_val("d_const", {bus.d_param, bus.d_sink, bus.d_user}, 5'd0);
    end
    if (rv) begin
      found = 0;
      foreach (exp_q[i]) begin
        if (!found && !exp_q[i].filled) begin
          exp_q[i].filled = 1;
          found = 1;
        end
      end
      if (!found) check_val("fill_target", 0, 1);
      void'(mem_q.pop_front());
    end
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(ne);
      a_pend = 0;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_opcode = 0; bus.a_size = 0; bus.a_source = 0;
    bus.a_address = 0; bus.a_mask = 0; bus.a_data = 0; bus.d_ready = 0;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0; bus.err = 0;
    a_op = 0; a_sz = 0; a_adr = 0; a_msk = 0; a_dat = 0; a_src = 0;

    repeat (2) @(negedge clk);
    #1;
    check_val("rst_req", bus.req, 0);
    check_val("rst_a_ready", bus.a_ready, 0);
    check_val("rst_d_valid", bus.d_valid, 0);
    check_val("rst_d_fields", {bus.d_opcode, bus.d_size, bus.d_source, bus.d_data, bus.d_error}, 0);
    @(negedge clk);
    rst = 0;

    repeat (1500) step(60, 70, 80, 60);
    repeat (1000) step(70, 50, 20, 50);
    repeat (500)  step(90, 100, 100, 100);

    // Reset with transactions outstanding; late memory responses must be dropped.
    begin
      int k = 0;
      while (!(mem_q.size() >= 1 && exp_q.size() == N) && k < 300) begin
        step(80, 100, 100, 0);
        k++;
      end
      check_val("reset_setup", (mem_q.size() >= 1) && (exp_q.size() == N), 1);
    end
    @(negedge clk);
    rst = 1;
    bus.a_valid = 0;
    bus.rvalid  = 0;
    a_pend = 0;
    #1;
    check_val("midrst_d_valid", bus.d_valid, 0);
    check_val("midrst_req", bus.req, 0);
    stale_n = mem_q.size();
    mem_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (stale_n + 2) step(0, 100, 100, 0);

    repeat (1000) step(60, 70, 70, 60);

    begin
      int k = 0;
      while ((exp_q.size() > 0 || a_pend) && k < 300) begin
        step(0, 100, 100, 100);
        k++;
      end
      check_val("drain_empty", exp_q.size() + mem_q.size() + int'(a_pend), 0);
    end
    #1;
    check_val("final_d_valid", bus.d_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
